// File: rtl/fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ctrl_pkg
// Description : Shared definitions for the FIFO controller: default sizes,
//               depth derivation and error-FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_ctrl_pkg;

  // Default geometry of the FIFO
  localparam int DEF_MAIN_SIZE = 8;
  localparam int DEF_DATA_SIZE = 10;

  // Error-tracking FSM: once an illegal access is seen it stays in ST_ERR
  typedef enum logic [0:0] {
    ST_OK  = 1'b0,
    ST_ERR = 1'b1
  } err_state_t;

  // Number of words addressable with a pointer of the given width
  function automatic int fifo_depth(input int main_size);
    return 1 << main_size;
  endfunction

endpackage : fifo_ctrl_pkg
`default_nettype wire

// File: rtl/fifo_ctrl_memory.sv
`default_nettype none
// ============================================================================
// Module      : memory
// Description : Simple dual-port RAM. Synchronous write; registered read
//               data is available one cycle after the read strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module memory
  import fifo_ctrl_pkg::*;
#(
  parameter int MAIN_SIZE = DEF_MAIN_SIZE,
  parameter int DATA_SIZE = DEF_DATA_SIZE
) (
  input  logic                 clk,
  input  logic                 write,
  input  logic                 read,
  input  logic [MAIN_SIZE-1:0] wr_ptr,
  input  logic [MAIN_SIZE-1:0] rd_ptr,
  input  logic [DATA_SIZE-1:0] data_in,
  output logic [DATA_SIZE-1:0] data_out
);

  localparam int DEPTH = fifo_depth(MAIN_SIZE);

  logic [DATA_SIZE-1:0] r_mem [DEPTH];
  logic [DATA_SIZE-1:0] r_rd_data;

  // Storage array: contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (write) begin
      r_mem[wr_ptr] <= data_in;
    end
  end

  // Registered read port; holds its value when no read is requested
  always_ff @(posedge clk) begin
    if (read) begin
      r_rd_data <= r_mem[rd_ptr];
    end
  end

  assign data_out = r_rd_data;

endmodule : memory
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ctrl
// Description : Synchronous FIFO controller. Owns the read/write pointers and
//               strobes of the dual-port memory, tracks occupancy and flags,
//               and latches a sticky error on overflow/underflow attempts.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int MAIN_SIZE = DEF_MAIN_SIZE,
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int AF_LVL    = (2 ** MAIN_SIZE) - 1,
  parameter int AE_LVL    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_SIZE-1:0] data_in,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [MAIN_SIZE:0]   fifo_count,
  output logic                 error
);

  localparam int DEPTH = fifo_depth(MAIN_SIZE);
  localparam int CNT_W = MAIN_SIZE + 1;

  localparam logic [CNT_W-1:0]     c_depth   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]     c_af_lvl  = CNT_W'(AF_LVL);
  localparam logic [CNT_W-1:0]     c_ae_lvl  = CNT_W'(AE_LVL);
  localparam logic [CNT_W-1:0]     c_cnt_one = CNT_W'(1);
  localparam logic [CNT_W-1:0]     c_cnt_zero = '0;
  localparam logic [MAIN_SIZE-1:0] c_ptr_one = MAIN_SIZE'(1);

  // Registered state
  logic [MAIN_SIZE-1:0] r_wr_ptr;
  logic [MAIN_SIZE-1:0] r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_full;
  logic                 r_empty;
  logic                 r_almost_full;
  logic                 r_almost_empty;
  logic                 r_rd_pend;
  logic                 r_valid;
  logic [DATA_SIZE-1:0] r_data_out;
  err_state_t           r_state;
  logic                 r_error;

  // Combinational helpers
  logic                 w_push_ok;
  logic                 w_pop_ok;
  logic                 w_bad_access;
  logic [CNT_W-1:0]     w_count_nxt;
  logic [DATA_SIZE-1:0] w_mem_rdata;

  // Accept requests only against the flags registered this cycle; a push into
  // a full FIFO is dropped even if a pop frees a slot in the same cycle.
  assign w_push_ok    = push & ~r_full;
  assign w_pop_ok     = pop  & ~r_empty;
  assign w_bad_access = (push & r_full) | (pop & r_empty);

  // Next occupancy: simultaneous accepted push and pop cancel out
  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop_ok) begin
      w_count_nxt = r_count + c_cnt_one;
    end else if (w_pop_ok && !w_push_ok) begin
      w_count_nxt = r_count - c_cnt_one;
    end
  end

  memory #(
    .MAIN_SIZE (MAIN_SIZE),
    .DATA_SIZE (DATA_SIZE)
  ) u_memory (
    .clk      (clk),
    .write    (w_push_ok),
    .read     (w_pop_ok),
    .wr_ptr   (r_wr_ptr),
    .rd_ptr   (r_rd_ptr),
    .data_in  (data_in),
    .data_out (w_mem_rdata)
  );

  // Pointers wrap naturally at DEPTH thanks to their MAIN_SIZE-bit width
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
    end
  end

  // Occupancy and status flags, all derived from the next count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_count        <= w_count_nxt;
      r_full         <= (w_count_nxt == c_depth);
      r_empty        <= (w_count_nxt == c_cnt_zero);
      r_almost_full  <= (w_count_nxt >= c_af_lvl);
      r_almost_empty <= (w_count_nxt <= c_ae_lvl);
    end
  end

  // Pop return path: the RAM delivers data one edge after the read strobe,
  // and it is captured into data_out on the following edge with a one-cycle
  // valid pulse; data_out holds its value between pops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_pend  <= 1'b0;
      r_valid    <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_rd_pend <= w_pop_ok;
      r_valid   <= r_rd_pend;
      if (r_rd_pend) begin
        r_data_out <= w_mem_rdata;
      end
    end
  end

  // Sticky error FSM: any illegal access latches ST_ERR until reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_OK;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        ST_OK: begin
          if (w_bad_access) begin
            r_state <= ST_ERR;
            r_error <= 1'b1;
          end
        end
        ST_ERR: begin
          r_state <= ST_ERR;
          r_error <= 1'b1;
        end
        default: begin
          r_state <= ST_ERR;
          r_error <= 1'b1;
        end
      endcase
    end
  end

  assign data_out     = r_data_out;
  assign valid_out    = r_valid;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign fifo_count   = r_count;
  assign error        = r_error;

endmodule : fifo_ctrl
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_ctrl
// Description : Self-checking bench for fifo_ctrl (MAIN_SIZE=2, DATA_SIZE=10,
//               AF_LVL=3, AE_LVL=1) against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl;

  localparam int MS    = 2;
  localparam int DS    = 10;
  localparam int DEPTH = 4;
  localparam int AFL   = 3;
  localparam int AEL   = 1;

  logic          clk;
  logic          reset;
  logic          push;
  logic          pop;
  logic [DS-1:0] data_in;
  logic [DS-1:0] data_out;
  logic          valid_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [MS:0]   fifo_count;
  logic          error;

  fifo_ctrl #(
    .MAIN_SIZE (MS),
    .DATA_SIZE (DS),
    .AF_LVL    (AFL),
    .AE_LVL    (AEL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .data_in      (data_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_count   (fifo_count),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Reference model: queue contents, sticky error, and the words that are in
  // flight on the way to data_out (delivered two edges after the pop).
  logic [DS-1:0] m_q[$];
  bit            m_err;
  bit            m_p1_valid;
  logic [DS-1:0] m_p1_data;
  bit            m_valid;
  logic [DS-1:0] m_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_err      = 1'b0;
    m_p1_valid = 1'b0;
    m_p1_data  = '0;
    m_valid    = 1'b0;
    m_dout     = '0;
  endtask

  task automatic check_all();
    int sz;
    sz = m_q.size();
    chk("count",        32'(fifo_count),   32'(sz));
    chk("full",         32'(full),         32'(sz == DEPTH));
    chk("empty",        32'(empty),        32'(sz == 0));
    chk("almost_full",  32'(almost_full),  32'(sz >= AFL));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= AEL));
    chk("error",        32'(error),        32'(m_err));
    chk("valid_out",    32'(valid_out),    32'(m_valid));
    chk("data_out",     32'(data_out),     32'(m_dout));
  endtask

  // One clock cycle of stimulus, model update at the edge, then checks
  task automatic step(input bit p, input bit po, input logic [DS-1:0] d);
    bit            full_m, empty_m, push_ok, pop_ok;
    logic [DS-1:0] popped;
    @(negedge clk);
    push    = p;
    pop     = po;
    data_in = d;
    @(posedge clk);
    full_m  = (m_q.size() == DEPTH);
    empty_m = (m_q.size() == 0);
    push_ok = p && !full_m;
    pop_ok  = po && !empty_m;
    if ((p && full_m) || (po && empty_m)) m_err = 1'b1;
    m_valid = m_p1_valid;
    if (m_p1_valid) m_dout = m_p1_data;
    popped = '0;
    if (pop_ok) popped = m_q.pop_front();
    if (push_ok) m_q.push_back(d);
    m_p1_valid = pop_ok;
    m_p1_data  = popped;
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  // Pulse reset low between edges and confirm the asynchronous clear
  task automatic async_reset();
    @(negedge clk);
    push  = 1'b0;
    pop   = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    m_reset();
    check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    push     = 1'b0;
    pop      = 1'b0;
    data_in  = '0;
    m_reset();

    // Reset, then release and stay idle
    async_reset();
    idle(3);

    // Fill and drain
    step(1'b1, 1'b0, 10'hFF);
    step(1'b1, 1'b0, 10'hDD);
    step(1'b1, 1'b0, 10'hEE);
    step(1'b1, 1'b0, 10'hCC);
    chk("fill_full", 32'(full), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0);
    idle(2);
    chk("drain_last", 32'(data_out), 32'h0CC);

    // Overflow: push while full is dropped
    step(1'b1, 1'b0, 10'hFF);
    step(1'b1, 1'b0, 10'hDD);
    step(1'b1, 1'b0, 10'hEE);
    step(1'b1, 1'b0, 10'hCC);
    step(1'b1, 1'b0, 10'hBB);
    chk("ovf_error", 32'(error), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0);
    idle(2);

    // Underflow, then push+pop on empty
    async_reset();
    step(1'b0, 1'b1, '0);
    idle(2);
    step(1'b1, 1'b1, 10'h99);
    chk("pp_empty_count", 32'(fifo_count), 32'd1);
    step(1'b0, 1'b1, '0);
    idle(2);
    chk("pp_empty_data", 32'(data_out), 32'h099);

    // Wrap with concurrent access at count 2
    step(1'b1, 1'b0, 10'hAA);
    step(1'b1, 1'b0, 10'h88);
    for (int i = 1; i <= 6; i++) step(1'b1, 1'b1, DS'(i));
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, '0);
    idle(2);

    // Reset mid-operation at count 3 with error set
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 10'h11);
    step(1'b1, 1'b0, 10'h22);
    step(1'b1, 1'b0, 10'h33);
    chk("pre_rst_err", 32'(error), 32'd1);
    async_reset();
    step(1'b1, 1'b0, 10'h55);
    step(1'b0, 1'b1, '0);
    idle(2);
    chk("post_rst_data", 32'(data_out), 32'h055);

    // Randomized traffic with occasional mid-run resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else begin
        step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
             DS'($urandom));
      end
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fifo_ctrl
`default_nettype wire
